// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath and pipe_hazard_ctrl.
//   master : pipeline side, drives ID/EX/MEM status and io_ack, receives latch controls
//   slave  : controller side, receives status, drives enables/flushes, io_req/io_err, stall_cnt
interface pipe_hazard_ctrl_if;
   // Operand usage of the instruction in ID
   logic [4:0]  rs1Addr_ID;
   logic [4:0]  rs2Addr_ID;
   logic        rs1Used_ID;
   logic        rs2Used_ID;
   // ID/EX latch outputs
   logic [4:0]  rdAddr_EX;
   logic        regWrite_EX;
   logic [1:0]  dataToReg_EX;
   logic        branchTaken_EX;
   // MEM stage I/O access
   logic        MIO_MEM;
   logic        memReq_MEM;
   logic        io_ack;
   // Latch controls
   logic        PC_EN;
   logic        IF_ID_EN;
   logic        IF_ID_flush;
   logic        ID_EX_EN;
   logic        ID_EX_flush;
   logic        EX_MEM_EN;
   logic        MEM_WB_EN;
   // Status
   logic        io_req;
   logic        io_err;
   logic [15:0] stall_cnt;

   modport master (
      output rs1Addr_ID, rs2Addr_ID, rs1Used_ID, rs2Used_ID,
      output rdAddr_EX, regWrite_EX, dataToReg_EX, branchTaken_EX,
      output MIO_MEM, memReq_MEM, io_ack,
      input  PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, MEM_WB_EN,
      input  io_req, io_err, stall_cnt
   );

   modport slave (
      input  rs1Addr_ID, rs2Addr_ID, rs1Used_ID, rs2Used_ID,
      input  rdAddr_EX, regWrite_EX, dataToReg_EX, branchTaken_EX,
      input  MIO_MEM, memReq_MEM, io_ack,
      output PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, MEM_WB_EN,
      output io_req, io_err, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
// Produces PC/IF-ID/ID-EX/EX-MEM/MEM-WB enables and IF-ID/ID-EX flushes:
//   - freezes the whole pipe while an MIO access in MEM awaits io_ack (bounded by TIMEOUT)
//   - squashes IF/ID and ID/EX on a taken branch resolved in EX
//   - inserts a one-cycle bubble on a load-use dependency
// Ports:
//   clk : core clock, rising edge
//   rst : asynchronous active-low reset
//   hz  : slave side of pipe_hazard_ctrl_if (status in, latch controls/status out)
// Parameters:
//   TIMEOUT : max IO_WAIT cycles before an MIO access is abandoned (>= 2)
module pipe_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic                clk,
   input logic                rst,
   pipe_hazard_ctrl_if.slave  hz
);

   localparam int unsigned CntW = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
   localparam logic [1:0] DataToRegLoad = 2'b01;

   typedef enum logic [1:0] {
      StRun,
      StIoWait,
      StIoDone
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              io_err_q, io_err_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;

   logic mio_start;
   logic freeze;
   logic load_use;
   logic rs1_hit;
   logic rs2_hit;

   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         cnt_q       <= '0;
         io_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         io_err_q    <= io_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      io_err_d    = io_err_q;
      stall_cnt_d = stall_cnt_q;

      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;

      // MIO_MEM is only looked at in RUN, so the IO_DONE release cycle cannot re-trigger.
      mio_start = (state_q == StRun) && hz.MIO_MEM && hz.memReq_MEM;
      freeze    = (state_q == StIoWait) || mio_start;

      rs1_hit  = hz.rs1Used_ID && (hz.rs1Addr_ID == hz.rdAddr_EX);
      rs2_hit  = hz.rs2Used_ID && (hz.rs2Addr_ID == hz.rdAddr_EX);
      load_use = (hz.dataToReg_EX == DataToRegLoad) && hz.regWrite_EX &&
                 (hz.rdAddr_EX != 5'd0) && (rs1_hit || rs2_hit);

      unique case (state_q)
         StRun: begin
            if (mio_start) begin
               state_d = StIoWait;
               cnt_d   = '0;
            end
         end
         StIoWait: begin
            // An ack in the timeout cycle still counts as a completed access.
            if (hz.io_ack) begin
               state_d = StIoDone;
            end else if (cnt_q == CntLast) begin
               state_d  = StIoDone;
               io_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StIoDone: begin
            state_d = StRun;
         end
         default: begin
            state_d = StRun;
         end
      endcase

      // IO_DONE keeps EX_MEM/MEM_WB enabled in every branch below, so the MIO
      // instruction always leaves MEM; branch/load-use handling stays live there.
      if (freeze) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (hz.branchTaken_EX) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
         if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end
      end

      // Hold every latch still while reset is asserted.
      if (!rst) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         if_id_flush = 1'b0;
         id_ex_en    = 1'b0;
         id_ex_flush = 1'b0;
         ex_mem_en   = 1'b0;
         mem_wb_en   = 1'b0;
      end
   end

   assign hz.PC_EN       = pc_en;
   assign hz.IF_ID_EN    = if_id_en;
   assign hz.IF_ID_flush = if_id_flush;
   assign hz.ID_EX_EN    = id_ex_en;
   assign hz.ID_EX_flush = id_ex_flush;
   assign hz.EX_MEM_EN   = ex_mem_en;
   assign hz.MEM_WB_EN   = mem_wb_en;
   assign hz.io_req      = (state_q == StIoWait);
   assign hz.io_err      = io_err_q;
   assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   // Control vector: {PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, MEM_WB_EN}
   localparam logic [6:0] CtlRun = 7'b1101011;
   localparam logic [6:0] CtlFrz = 7'b0000000;
   localparam logic [6:0] CtlBr  = 7'b1111111;
   localparam logic [6:0] CtlLu  = 7'b0001111;

   typedef struct {
      string       tag;
      logic [6:0]  ctl;
      logic        req;
      logic        err;
      logic [15:0] stall;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   pipe_hazard_ctrl_if hz_if ();

   pipe_hazard_ctrl #(
      .TIMEOUT (4)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz_if)
   );

   always #5 clk = ~clk;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_stall = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Push the expectation for this cycle, then pop it against the DUT outputs.
   task automatic expect_now(input string tag, input logic [6:0] ctl, input logic req,
                             input logic err);
      exp_t e;
      exp_t p;
      logic [6:0] act_ctl;
      e.tag = tag; e.ctl = ctl; e.req = req; e.err = err; e.stall = exp_stall;
      sb_q.push_back(e);
      p = sb_q.pop_front();
      act_ctl = {hz_if.PC_EN, hz_if.IF_ID_EN, hz_if.IF_ID_flush, hz_if.ID_EX_EN,
                 hz_if.ID_EX_flush, hz_if.EX_MEM_EN, hz_if.MEM_WB_EN};
      check_eq($sformatf("%s.ctl", p.tag), 32'(act_ctl), 32'(p.ctl));
      check_eq($sformatf("%s.io_req", p.tag), 32'(hz_if.io_req), 32'(p.req));
      check_eq($sformatf("%s.io_err", p.tag), 32'(hz_if.io_err), 32'(p.err));
      check_eq($sformatf("%s.stall_cnt", p.tag), 32'(hz_if.stall_cnt), 32'(p.stall));
   endtask

   // Called at posedge+1 with inputs set; samples at the falling edge.
   task automatic cyc(input string tag, input logic [6:0] ctl, input logic req, input logic err);
      #4;
      expect_now(tag, ctl, req, err);
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      hz_if.rs1Addr_ID     = 5'd1;
      hz_if.rs2Addr_ID     = 5'd2;
      hz_if.rs1Used_ID     = 1'b0;
      hz_if.rs2Used_ID     = 1'b0;
      hz_if.rdAddr_EX      = 5'd0;
      hz_if.regWrite_EX    = 1'b0;
      hz_if.dataToReg_EX   = 2'b00;
      hz_if.branchTaken_EX = 1'b0;
      hz_if.MIO_MEM        = 1'b0;
      hz_if.memReq_MEM     = 1'b0;
      hz_if.io_ack         = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
      hz_if.rdAddr_EX    = rd;
      hz_if.regWrite_EX  = 1'b1;
      hz_if.dataToReg_EX = 2'b01;
      hz_if.rs1Addr_ID   = rs1;
      hz_if.rs1Used_ID   = u1;
      hz_if.rs2Addr_ID   = rs2;
      hz_if.rs2Used_ID   = u2;
   endtask

   task automatic set_mio(input logic m, input logic ack);
      hz_if.MIO_MEM    = m;
      hz_if.memReq_MEM = m;
      hz_if.io_ack     = ack;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset with a hazard present: everything must stay low.
      rst = 1'b0;
      set_idle();
      set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
      #2;
      expect_now("reset", CtlFrz, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      expect_now("reset_edge", CtlFrz, 1'b0, 1'b0);
      rst = 1'b1;
      set_idle();
      cyc("idle", CtlRun, 1'b0, 1'b0);

      // Load-use via rs2, then bubble clears it.
      set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
      cyc("lu_rs2", CtlLu, 1'b0, 1'b0);
      exp_stall++;
      set_idle();
      hz_if.rs1Addr_ID = 5'd5; hz_if.rs1Used_ID = 1'b1;
      cyc("lu_bubble", CtlRun, 1'b0, 1'b0);
      set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      cyc("lu_rd0", CtlRun, 1'b0, 1'b0);
      set_lu(5'd7, 5'd7, 1'b1, 5'd2, 1'b0);
      cyc("lu_rs1", CtlLu, 1'b0, 1'b0);
      exp_stall++;
      set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b0);
      cyc("lu_rs2_unused", CtlRun, 1'b0, 1'b0);
      set_lu(5'd7, 5'd7, 1'b1, 5'd7, 1'b1);
      hz_if.dataToReg_EX = 2'b00;
      cyc("lu_not_load", CtlRun, 1'b0, 1'b0);

      // Branch beats load-use.
      set_lu(5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
      hz_if.branchTaken_EX = 1'b1;
      cyc("br_lu", CtlBr, 1'b0, 1'b0);
      set_idle();
      cyc("br_after", CtlRun, 1'b0, 1'b0);

      // MIO store, ack three cycles after io_req rises.
      set_mio(1'b1, 1'b0);
      cyc("mio_detect", CtlFrz, 1'b0, 1'b0);
      set_lu(5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
      cyc("mio_wait1_lu", CtlFrz, 1'b1, 1'b0);
      hz_if.branchTaken_EX = 1'b1;
      cyc("mio_wait2_br", CtlFrz, 1'b1, 1'b0);
      set_idle();
      set_mio(1'b1, 1'b1);
      cyc("mio_wait3_ack", CtlFrz, 1'b1, 1'b0);
      set_mio(1'b1, 1'b0);
      cyc("mio_done", CtlRun, 1'b0, 1'b0);
      set_idle();
      cyc("mio_after", CtlRun, 1'b0, 1'b0);

      // Ack coincides with last count; then back-to-back MIO.
      set_mio(1'b1, 1'b0);
      cyc("co_detect", CtlFrz, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc($sformatf("co_wait%0d", i), CtlFrz, 1'b1, 1'b0);
      set_mio(1'b1, 1'b1);
      cyc("co_ack_last", CtlFrz, 1'b1, 1'b0);
      set_mio(1'b1, 1'b0);
      cyc("co_done", CtlRun, 1'b0, 1'b0);
      cyc("b2b_detect", CtlFrz, 1'b0, 1'b0);
      set_mio(1'b1, 1'b1);
      cyc("b2b_wait_ack", CtlFrz, 1'b1, 1'b0);
      set_mio(1'b0, 1'b0);
      cyc("b2b_done", CtlRun, 1'b0, 1'b0);

      // Timeout: io_req for exactly four cycles, io_err sticks.
      set_mio(1'b1, 1'b0);
      cyc("to_detect", CtlFrz, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc($sformatf("to_wait%0d", i), CtlFrz, 1'b1, 1'b0);
      cyc("to_done", CtlRun, 1'b0, 1'b1);
      set_idle();
      cyc("to_after", CtlRun, 1'b0, 1'b1);
      set_mio(1'b1, 1'b0);
      cyc("nx_detect", CtlFrz, 1'b0, 1'b1);
      set_mio(1'b1, 1'b1);
      cyc("nx_wait_ack", CtlFrz, 1'b1, 1'b1);
      set_idle();
      cyc("nx_done", CtlRun, 1'b0, 1'b1);

      // Saturate stall_cnt.
      set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk);
         if (exp_stall != 16'hFFFF) exp_stall++;
      end
      #1;
      cyc("sat_lu", CtlLu, 1'b0, 1'b1);
      set_idle();
      cyc("sat_hold", CtlRun, 1'b0, 1'b1);

      // Reset in the middle of IO_WAIT.
      set_mio(1'b1, 1'b0);
      cyc("rw_detect", CtlFrz, 1'b0, 1'b1);
      cyc("rw_wait", CtlFrz, 1'b1, 1'b1);
      rst = 1'b0;
      exp_stall = '0;
      #2;
      expect_now("rw_reset", CtlFrz, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_idle();
      cyc("rw_run", CtlRun, 1'b0, 1'b0);
      set_mio(1'b1, 1'b0);
      cyc("rw_detect2", CtlFrz, 1'b0, 1'b0);
      set_mio(1'b1, 1'b1);
      cyc("rw_wait_ack", CtlFrz, 1'b1, 1'b0);
      set_idle();
      cyc("rw_done", CtlRun, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
